wb_gain_pipe: RTL and testbench



---
 rtl/wb_gain_pipe_if.sv | 33 +++
 rtl/wb_gain_pipe.sv | 100 ++++++++++
 tb/tb_wb_gain_pipe.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_gain_pipe_if.sv
// rtl/wb_gain_pipe_if.sv - pixel, gain and output handshake bundle for the white-balance gain stage
interface wb_gain_pipe_if #(
  parameter int DW  = 8,
  parameter int GW  = 16,
  parameter int NCH = 4
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic              valid_value_i;
  logic              ready_o;
  logic              sof_i;
  logic [CW-1:0]     color_i;
  logic [DW-1:0]     value_i;
  logic              valid_gain_i;
  logic [NCH*GW-1:0] gain_i;
  logic              valid_o;
  logic              ready_i;
  logic              sof_o;
  logic [CW-1:0]     color_o;
  logic [DW-1:0]     value_o;
  logic              sat_o;
  logic [15:0]       sat_cnt_o;

  modport slave (
    input  valid_value_i, sof_i, color_i, value_i, valid_gain_i, gain_i, ready_i,
    output ready_o, valid_o, sof_o, color_o, value_o, sat_o, sat_cnt_o
  );

  modport master (
    output valid_value_i, sof_i, color_i, value_i, valid_gain_i, gain_i, ready_i,
    input  ready_o, valid_o, sof_o, color_o, value_o, sat_o, sat_cnt_o
  );
endinterface

// File: rtl/wb_gain_pipe.sv
// rtl/wb_gain_pipe.sv - per-channel fixed-point gain with round-half-up, saturation and frame stats
module wb_gain_pipe #(
  parameter int DW  = 8,
  parameter int GW  = 16,
  parameter int GF  = 12,
  parameter int NCH = 4
) (
  input logic           clk,
  input logic           rst_n,
  wb_gain_pipe_if.slave bus
);
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = DW + GW + 1;
  localparam int RSH = (GF > 0) ? GF - 1 : 0;
  localparam logic [GW-1:0]     UNITY  = GW'(1) << GF;
  localparam logic [NCH*GW-1:0] UNITYS = {NCH{UNITY}};
  localparam logic [PW-1:0]     RND    = (GF > 0) ? (PW'(1) << RSH) : '0;
  localparam logic [PW-1:0]     MAXV   = {{(PW-DW){1'b0}}, {DW{1'b1}}};

  logic [NCH*GW-1:0] pend_bank;
  logic [NCH*GW-1:0] act_bank;
  logic [NCH*GW-1:0] sel_bank;
  logic [GW-1:0]     g_sel;

  logic              s1_valid;
  logic              s1_sof;
  logic [CW-1:0]     s1_color;
  logic [DW-1:0]     s1_value;
  logic [GW-1:0]     s1_gain;

  logic              adv;
  logic              accept;
  logic              load;
  logic [PW-1:0]     prod;
  logic [PW-1:0]     rnd;
  logic              sat_c;
  logic [DW-1:0]     val_c;

  assign adv         = !bus.valid_o || bus.ready_i;
  assign bus.ready_o = adv;
  assign accept      = bus.valid_value_i && adv;
  assign load        = accept && bus.sof_i;

  // A sof pixel sees the bank it is about to install, including a same-cycle write.
  assign sel_bank = load ? (bus.valid_gain_i ? bus.gain_i : pend_bank) : act_bank;

  always_comb begin
    g_sel = UNITY;
    if (int'(bus.color_i) < NCH) g_sel = sel_bank[int'(bus.color_i)*GW +: GW];
  end

  assign prod  = PW'(s1_value) * PW'(s1_gain);
  assign rnd   = (prod + RND) >> GF;
  assign sat_c = rnd > MAXV;
  assign val_c = sat_c ? {DW{1'b1}} : rnd[DW-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_bank     <= UNITYS;
      act_bank      <= UNITYS;
      s1_valid      <= 1'b0;
      s1_sof        <= 1'b0;
      s1_color      <= '0;
      s1_value      <= '0;
      s1_gain       <= '0;
      bus.valid_o   <= 1'b0;
      bus.sof_o     <= 1'b0;
      bus.color_o   <= '0;
      bus.value_o   <= '0;
      bus.sat_o     <= 1'b0;
      bus.sat_cnt_o <= '0;
    end else begin
      if (bus.valid_gain_i) pend_bank <= bus.gain_i;
      if (load) act_bank <= sel_bank;

      if (adv) begin
        s1_valid <= bus.valid_value_i;
        if (accept) begin
          s1_sof   <= bus.sof_i;
          s1_color <= bus.color_i;
          s1_value <= bus.value_i;
          s1_gain  <= g_sel;
        end
        bus.valid_o <= s1_valid;
        if (s1_valid) begin
          bus.sof_o   <= s1_sof;
          bus.color_o <= s1_color;
          bus.value_o <= val_c;
          bus.sat_o   <= sat_c;
        end
      end

      // Counts the frame currently leaving; restarts on its sof pixel.
      if (bus.valid_o && bus.ready_i) begin
        if (bus.sof_o) bus.sat_cnt_o <= {15'd0, bus.sat_o};
        else if (bus.sat_o && bus.sat_cnt_o != 16'hFFFF) bus.sat_cnt_o <= bus.sat_cnt_o + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_wb_gain_pipe.sv
// tb/tb_wb_gain_pipe.sv - directed bench for wb_gain_pipe
module tb_wb_gain_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] q_val[$];
  logic       q_sat[$];
  logic [1:0] q_col[$];

  always #5 clk = ~clk;

  wb_gain_pipe_if #(.DW(8), .GW(16), .NCH(4)) bus ();

  wb_gain_pipe #(.DW(8), .GW(16), .GF(12), .NCH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always @(negedge clk) begin
    if (rst_n && bus.valid_o && bus.ready_i) begin
      q_val.push_back(bus.value_o);
      q_sat.push_back(bus.sat_o);
      q_col.push_back(bus.color_o);
    end
  end

  task automatic idle();
    bus.valid_value_i = 1'b0;
    bus.sof_i = 1'b0;
    bus.valid_gain_i = 1'b0;
  endtask

  task automatic clear_q();
    q_val.delete();
    q_sat.delete();
    q_col.delete();
  endtask

  task automatic push_pix(input logic sof, input logic [1:0] col, input logic [7:0] v,
                          input logic wg = 1'b0, input logic [63:0] g = 64'd0);
    logic acc;
    int n;
    bus.valid_value_i = 1'b1;
    bus.sof_i = sof;
    bus.color_i = col;
    bus.value_i = v;
    bus.valid_gain_i = wg;
    bus.gain_i = g;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: pixel value %0d not accepted within 50 cycles", v);
    end
    idle();
  endtask

  task automatic wait_out(input int n);
    int k;
    k = 0;
    while (q_val.size() < n && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (q_val.size() != n) begin
      n_fail++;
      $display("FAIL out_count: got %0d outputs, expected %0d", q_val.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ready_i = 1'b1;
    bus.color_i = '0;
    bus.value_i = '0;
    bus.gain_i = '0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", bus.valid_o); end
    n_checks++; if (bus.value_o !== 8'd0) begin n_fail++; $display("FAIL rst_value: got %0d expected 0", bus.value_o); end
    n_checks++; if (bus.sat_o !== 1'b0) begin n_fail++; $display("FAIL rst_sat: got %b expected 0", bus.sat_o); end
    n_checks++; if (bus.sat_cnt_o !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d expected 0", bus.sat_cnt_o); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", bus.ready_o); end
  endtask

  task automatic test_latency();
    clear_q();
    push_pix(1'b1, 2'd0, 8'd15);
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL lat_early: got valid %b expected 0", bus.valid_o); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.valid_o !== 1'b1) begin n_fail++; $display("FAIL lat_valid: got %b expected 1", bus.valid_o); end
    n_checks++; if (bus.value_o !== 8'd15) begin n_fail++; $display("FAIL lat_value: got %0d expected 15", bus.value_o); end
    n_checks++; if (bus.sat_o !== 1'b0) begin n_fail++; $display("FAIL lat_sat: got %b expected 0", bus.sat_o); end
    n_checks++; if (bus.sof_o !== 1'b1) begin n_fail++; $display("FAIL lat_sof: got %b expected 1", bus.sof_o); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL lat_drop: got valid %b expected 0", bus.valid_o); end
    n_checks++; if (bus.sat_cnt_o !== 16'd0) begin n_fail++; $display("FAIL lat_cnt: got %0d expected 0", bus.sat_cnt_o); end
  endtask

  task automatic test_gain_sat();
    logic [7:0] ev [3];
    logic       es [3];
    ev = '{8'd15, 8'd255, 8'd255};
    es = '{1'b0, 1'b1, 1'b1};
    clear_q();
    push_pix(1'b1, 2'd0, 8'd15, 1'b1, {16'h1000, 16'h1800, 16'hCCCC, 16'h0FF0});
    push_pix(1'b0, 2'd1, 8'd240);
    push_pix(1'b0, 2'd2, 8'd200);
    wait_out(3);
    for (int i = 0; i < 3 && i < q_val.size(); i++) begin
      n_checks++; if (q_val[i] !== ev[i]) begin n_fail++; $display("FAIL sat_value[%0d]: got %0d expected %0d", i, q_val[i], ev[i]); end
      n_checks++; if (q_sat[i] !== es[i]) begin n_fail++; $display("FAIL sat_flag[%0d]: got %b expected %b", i, q_sat[i], es[i]); end
    end
    n_checks++; if (bus.sat_cnt_o !== 16'd2) begin n_fail++; $display("FAIL sat_cnt: got %0d expected 2", bus.sat_cnt_o); end
  endtask

  task automatic test_rounding();
    logic [7:0] ev [3];
    ev = '{8'd2, 8'd1, 8'd0};
    clear_q();
    push_pix(1'b1, 2'd3, 8'd3, 1'b1, {16'h0800, 16'h0000, 16'h1000, 16'h1000});
    push_pix(1'b0, 2'd3, 8'd2);
    push_pix(1'b0, 2'd2, 8'd200);
    wait_out(3);
    for (int i = 0; i < 3 && i < q_val.size(); i++) begin
      n_checks++; if (q_val[i] !== ev[i]) begin n_fail++; $display("FAIL round_value[%0d]: got %0d expected %0d", i, q_val[i], ev[i]); end
      n_checks++; if (q_sat[i] !== 1'b0) begin n_fail++; $display("FAIL round_sat[%0d]: got %b expected 0", i, q_sat[i]); end
    end
    n_checks++; if (bus.sat_cnt_o !== 16'd0) begin n_fail++; $display("FAIL round_cnt: got %0d expected 0", bus.sat_cnt_o); end
  endtask

  task automatic test_gain_update();
    logic [7:0] ev [6];
    ev = '{8'd10, 8'd10, 8'd10, 8'd20, 8'd20, 8'd20};
    clear_q();
    push_pix(1'b0, 2'd0, 8'd10, 1'b1, {16'h1000, 16'h1000, 16'h1000, 16'h2000});
    push_pix(1'b0, 2'd0, 8'd10);
    push_pix(1'b0, 2'd0, 8'd10);
    push_pix(1'b1, 2'd0, 8'd10);
    bus.valid_gain_i = 1'b1;
    bus.gain_i = {16'h1000, 16'h1000, 16'h1000, 16'h3000};
    @(posedge clk);
    #1;
    bus.valid_gain_i = 1'b0;
    push_pix(1'b1, 2'd0, 8'd10, 1'b1, {16'h1000, 16'h1000, 16'h1000, 16'h2000});
    push_pix(1'b0, 2'd0, 8'd10);
    wait_out(6);
    for (int i = 0; i < 6 && i < q_val.size(); i++) begin
      n_checks++; if (q_val[i] !== ev[i]) begin n_fail++; $display("FAIL upd_value[%0d]: got %0d expected %0d", i, q_val[i], ev[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ev [6];
    logic [1:0] ec [6];
    ev = '{8'd20, 8'd20, 8'd30, 8'd40, 8'd100, 8'd60};
    ec = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    clear_q();
    fork
      begin
        push_pix(1'b1, 2'd0, 8'd10, 1'b1, {16'h1000, 16'h1000, 16'h1000, 16'h2000});
        push_pix(1'b0, 2'd1, 8'd20);
        push_pix(1'b0, 2'd2, 8'd30);
        push_pix(1'b0, 2'd3, 8'd40);
        push_pix(1'b0, 2'd0, 8'd50);
        push_pix(1'b0, 2'd1, 8'd60);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        bus.ready_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          n_checks++; if (bus.ready_o !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b expected 0", s, bus.ready_o); end
          n_checks++; if (bus.valid_o !== 1'b1 || bus.value_o !== 8'd20 || bus.color_o !== 2'd0) begin
            n_fail++; $display("FAIL stall_hold[%0d]: got valid %b value %0d color %0d expected 1/20/0", s, bus.valid_o, bus.value_o, bus.color_o);
          end
          @(posedge clk);
          #1;
        end
        bus.ready_i = 1'b1;
      end
    join
    wait_out(6);
    for (int i = 0; i < 6 && i < q_val.size(); i++) begin
      n_checks++; if (q_val[i] !== ev[i] || q_col[i] !== ec[i]) begin
        n_fail++; $display("FAIL b2b[%0d]: got value %0d color %0d expected %0d/%0d", i, q_val[i], q_col[i], ev[i], ec[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    push_pix(1'b1, 2'd0, 8'd200, 1'b1, {16'h1000, 16'h1000, 16'h1000, 16'hFFFF});
    push_pix(1'b0, 2'd0, 8'd100);
    push_pix(1'b0, 2'd0, 8'd50);
    n_checks++; if (bus.sat_cnt_o !== 16'd1) begin n_fail++; $display("FAIL mid_cnt_pre: got %0d expected 1", bus.sat_cnt_o); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", bus.valid_o); end
    n_checks++; if (bus.sat_cnt_o !== 16'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d expected 0", bus.sat_cnt_o); end
    n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b expected 1", bus.ready_o); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_dropped: got valid %b expected 0", bus.valid_o); end
    clear_q();
    push_pix(1'b0, 2'(3'd5), 8'd77);
    push_pix(1'b0, 2'd0, 8'd200);
    wait_out(2);
    if (q_val.size() == 2) begin
      n_checks++; if (q_val[0] !== 8'd77) begin n_fail++; $display("FAIL mid_unity_c5: got %0d expected 77", q_val[0]); end
      n_checks++; if (q_val[1] !== 8'd200 || q_sat[1] !== 1'b0) begin n_fail++; $display("FAIL mid_unity_c0: got %0d sat %b expected 200 sat 0", q_val[1], q_sat[1]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_gain_sat();
    test_rounding();
    test_gain_update();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
